mii_rx_framer: RTL and testbench
================================

// Module: mii_rx_framer
// PURPOSE
//  Front end of the Ethernet receive path. Oversamples the 25 MHz MII receive interface (eth_rx_clk/dv/rxd/rxerr) in the mainclk domain.
//  Strips preamble/SFD, assembles nibbles into bytes (low nibble first) and checks length and FCS (CRC-32).
//  Emits a byte stream with SOF/EOF/error markers into the frame buffer / block-RAM writer downstream.
// PARAMETERS
//  MIN_LEN  64    minimum frame bytes incl. FCS; shorter -> runt error
//  MAX_LEN  1518  maximum frame bytes incl. FCS; longer -> oversize error, emission stops
//  PRE_MAX  16    max preamble nibbles before SFD; exceeded -> abort frame
// PORTS
//  mainclk     in   1   100 MHz system clock
//  rst         in   1   synchronous, active-high reset
//  enable      in   1   1 = accept new frames; sampled only in IDLE
//  eth_rx_clk  in   1   PHY RX clock (async, 25 MHz)
//  eth_rx_dv   in   1   PHY data valid (async)
//  eth_rxd     in   4   PHY nibble (async)
//  eth_rxerr   in   1   PHY receive error (async)
//  out_data    out  8   frame byte, valid with out_valid
//  out_valid   out  1   1-cycle strobe per byte
//  out_sof     out  1   with out_valid: first byte of frame
//  out_eof     out  1   with out_valid: last byte of frame
//  out_err     out  1   with out_eof: frame bad (rxerr/odd nibble/runt/oversize/FCS)
//  frame_len   out  11  byte count of last frame, updated on EOF, saturates at 2047
//  frame_cnt   out  16  good frames, wraps
//  err_cnt     out  16  bad + aborted frames, wraps
// BEHAVIOUR
//  Sync: eth_rx_clk, dv, rxd, rxerr each pass through identical 2-FF synchronizers; a 3rd FF on rx_clk gives edge detect.
//  Nibble sample strobe = falling edge of synced rx_clk (mid-bit for MII); all logic below advances only on strobe.
//  Reset: state=WAIT_IDLE; all outputs 0; counters 0; CRC=32'hFFFFFFFF.
//  States:
//   WAIT_IDLE: dv==0 at strobe -> IDLE. Prevents framing mid-packet after reset or abort.
//   IDLE: dv==1 && enable -> PREAMBLE (pre_cnt=1, nibble must be 5, else ABORT).
//         dv==1 && !enable -> WAIT_IDLE.
//   PREAMBLE: nibble 4'h5 -> pre_cnt++; 4'hD -> DATA (phase=0, len=0, crc init).
//     dv==0 -> IDLE, no output, no counts. Other nibble or pre_cnt>PRE_MAX -> ABORT.
//   DATA: phase0 latches low nibble; phase1 forms {hi,lo}, len++, crc update.
//     Byte is held one byte, so EOF can mark it: when a new byte forms, the held byte
//     is emitted (out_sof on first emission of frame); new byte becomes held.
//     dv==0 -> emit held byte with out_eof=1, out_err set per checks, -> IDLE.
//     rxerr==1 at any DATA strobe sets sticky err.
//   ABORT: err_cnt++ once on entry; no further emission. If a byte was already
//     emitted, emit a zero-data EOF strobe with out_err=1 on entry. Then -> WAIT_IDLE.
//  Checks at EOF: err = rxerr_seen | (phase==1 odd nibble) | len<MIN_LEN | len>MAX_LEN
//    | crc residue != 32'hC704DD7B (CRC-32, poly 04C11DB7, reflected, over all bytes incl FCS).
//  Oversize: at len==MAX_LEN+1 stop emitting, keep counting (saturating); EOF strobe still issued when dv falls.
//  EOF: frame_len<=len, frame_cnt++ if !err else err_cnt++, same cycle as out_eof.
//  Outputs are registered; out_valid is high exactly 1 mainclk cycle; min spacing 8 cycles.
//  Latency: byte emitted 1 mainclk after the strobe that completes the following byte, or after dv-fall strobe.
//  No backpressure: downstream must accept every strobe.
//  rst mid-frame: immediate return to WAIT_IDLE, outputs 0, partial frame dropped silently.
// TESTING
//  1. 7x55+D5 preamble, 64-byte frame with correct FCS -> 64 strobes, SOF on byte0, EOF on byte63, err=0, frame_len=64, frame_cnt=1.
//  2. Same frame, one FCS bit flipped -> 64 strobes, EOF err=1, err_cnt=1, frame_cnt unchanged.
//  3. 40-byte frame with valid FCS -> EOF err=1 (runt), frame_len=40; 1600-byte frame -> 1518 strobes + EOF err=1, frame_len=1600.
//  4. Preamble nibble 4'h7 before SFD -> no strobes, err_cnt++, ignores remainder until dv low; next good frame accepted.
//  5. rxerr pulse mid-frame, then odd nibble count on a second frame -> both EOF err=1.
//  6. rst asserted mid-frame and released while dv=1 -> no output for that frame; next frame (after dv low) received correctly; enable=0 -> frame ignored.

Source files
------------

// File: rtl/mii_rx_framer.sv
// MII receive framer: oversamples the PHY nibble interface, strips preamble/SFD,
// assembles bytes, checks length and FCS, and emits a byte stream with SOF/EOF/error markers.
module mii_rx_framer #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned PRE_MAX = 16
) (
    input  logic        mainclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        eth_rx_clk,
    input  logic        eth_rx_dv,
    input  logic [3:0]  eth_rxd,
    input  logic        eth_rxerr,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic [10:0] frame_len,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned LEN_W = 11;
    localparam int unsigned PRE_W = $clog2(PRE_MAX + 1);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_ABORT
    } state_t;

    // LSB-first CRC-32 over one byte
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    // Two-stage synchronizers; the extra rx_clk stage gives the falling-edge strobe
    logic [1:0] clk_sync, dv_sync, err_sync;
    logic [3:0] rxd_s1, rxd_s2;
    logic       clk_s3;

    always_ff @(posedge mainclk) begin
        if (rst) begin
            clk_sync <= '0;
            dv_sync  <= '0;
            err_sync <= '0;
            rxd_s1   <= '0;
            rxd_s2   <= '0;
            clk_s3   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], eth_rx_clk};
            dv_sync  <= {dv_sync[0], eth_rx_dv};
            err_sync <= {err_sync[0], eth_rxerr};
            rxd_s1   <= eth_rxd;
            rxd_s2   <= rxd_s1;
            clk_s3   <= clk_sync[1];
        end
    end

    logic       strobe, dv_s, rxerr_s;
    logic [3:0] rxd_s;
    assign strobe  = clk_s3 & ~clk_sync[1];
    assign dv_s    = dv_sync[1];
    assign rxerr_s = err_sync[1];
    assign rxd_s   = rxd_s2;

    state_t             state, state_nxt;
    logic [PRE_W-1:0]   pre_cnt, pre_cnt_nxt;
    logic               phase, phase_nxt;
    logic [3:0]         lo_nib, lo_nib_nxt;
    logic [7:0]         held, held_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [31:0]        crc, crc_nxt;
    logic               rxerr_seen, rxerr_seen_nxt;
    logic               sof_done, sof_done_nxt;
    logic [7:0]         out_data_nxt;
    logic               out_valid_nxt, out_sof_nxt, out_eof_nxt, out_err_nxt;
    logic [10:0]        frame_len_nxt;
    logic [15:0]        frame_cnt_nxt, err_cnt_nxt;

    logic [7:0]         rx_byte;
    logic [LEN_W-1:0]   len_inc;
    logic               eof_bad;
    logic               abort_c;

    assign rx_byte = {rxd_s, lo_nib};
    assign len_inc = (len == '1) ? len : len + LEN_W'(1);
    assign eof_bad = rxerr_seen | phase
                   | (len < LEN_W'(MIN_LEN)) | (len > LEN_W'(MAX_LEN))
                   | (bitrev32(crc) != CRC_RESIDUE);

    always_ff @(posedge mainclk) begin
        if (rst) state <= S_WAIT_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and registered-output logic; everything advances on the nibble strobe
    always_comb begin
        state_nxt      = state;
        pre_cnt_nxt    = pre_cnt;
        phase_nxt      = phase;
        lo_nib_nxt     = lo_nib;
        held_nxt       = held;
        len_nxt        = len;
        crc_nxt        = crc;
        rxerr_seen_nxt = rxerr_seen;
        sof_done_nxt   = sof_done;
        out_data_nxt   = out_data;
        out_valid_nxt  = 1'b0;
        out_sof_nxt    = 1'b0;
        out_eof_nxt    = 1'b0;
        out_err_nxt    = 1'b0;
        frame_len_nxt  = frame_len;
        frame_cnt_nxt  = frame_cnt;
        err_cnt_nxt    = err_cnt;
        abort_c        = 1'b0;

        case (state)
            S_WAIT_IDLE: begin
                if (strobe && !dv_s) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (strobe && dv_s) begin
                    if (!enable) begin
                        state_nxt = S_WAIT_IDLE;
                    end else if (rxd_s == 4'h5) begin
                        state_nxt   = S_PREAMBLE;
                        pre_cnt_nxt = PRE_W'(1);
                    end else begin
                        abort_c = 1'b1;
                    end
                end
            end
            S_PREAMBLE: begin
                if (strobe) begin
                    if (!dv_s) begin
                        state_nxt = S_IDLE;
                    end else if (rxd_s == 4'hD) begin
                        state_nxt      = S_DATA;
                        phase_nxt      = 1'b0;
                        len_nxt        = '0;
                        crc_nxt        = '1;
                        rxerr_seen_nxt = 1'b0;
                        sof_done_nxt   = 1'b0;
                    end else if (rxd_s == 4'h5 && pre_cnt < PRE_W'(PRE_MAX)) begin
                        pre_cnt_nxt = pre_cnt + PRE_W'(1);
                    end else begin
                        abort_c = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (strobe) begin
                    if (!dv_s) begin
                        // End of frame: release the held byte (or a bare marker if oversize)
                        state_nxt     = S_IDLE;
                        sof_done_nxt  = 1'b0;
                        frame_len_nxt = len;
                        if (eof_bad) err_cnt_nxt   = err_cnt + 16'd1;
                        else         frame_cnt_nxt = frame_cnt + 16'd1;
                        if (len != '0) begin
                            out_valid_nxt = 1'b1;
                            out_eof_nxt   = 1'b1;
                            out_err_nxt   = eof_bad;
                            out_sof_nxt   = ~sof_done;
                            out_data_nxt  = (len <= LEN_W'(MAX_LEN)) ? held : 8'd0;
                        end
                    end else begin
                        rxerr_seen_nxt = rxerr_seen | rxerr_s;
                        if (!phase) begin
                            lo_nib_nxt = rxd_s;
                            phase_nxt  = 1'b1;
                        end else begin
                            phase_nxt = 1'b0;
                            len_nxt   = len_inc;
                            crc_nxt   = crc_byte(crc, rx_byte);
                            held_nxt  = rx_byte;
                            if (len != '0 && len <= LEN_W'(MAX_LEN)) begin
                                out_valid_nxt = 1'b1;
                                out_data_nxt  = held;
                                out_sof_nxt   = ~sof_done;
                                sof_done_nxt  = 1'b1;
                            end
                        end
                    end
                end
            end
            S_ABORT: begin
                state_nxt = S_WAIT_IDLE;
            end
            default: begin
                state_nxt = S_WAIT_IDLE;
            end
        endcase

        if (abort_c) begin
            state_nxt    = S_ABORT;
            err_cnt_nxt  = err_cnt + 16'd1;
            sof_done_nxt = 1'b0;
            if (sof_done) begin
                out_valid_nxt = 1'b1;
                out_eof_nxt   = 1'b1;
                out_err_nxt   = 1'b1;
                out_data_nxt  = 8'd0;
            end
        end
    end

    always_ff @(posedge mainclk) begin
        if (rst) begin
            pre_cnt    <= '0;
            phase      <= 1'b0;
            lo_nib     <= '0;
            held       <= '0;
            len        <= '0;
            crc        <= 32'hFFFFFFFF;
            rxerr_seen <= 1'b0;
            sof_done   <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_err    <= 1'b0;
            frame_len  <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            pre_cnt    <= pre_cnt_nxt;
            phase      <= phase_nxt;
            lo_nib     <= lo_nib_nxt;
            held       <= held_nxt;
            len        <= len_nxt;
            crc        <= crc_nxt;
            rxerr_seen <= rxerr_seen_nxt;
            sof_done   <= sof_done_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            out_sof    <= out_sof_nxt;
            out_eof    <= out_eof_nxt;
            out_err    <= out_err_nxt;
            frame_len  <= frame_len_nxt;
            frame_cnt  <= frame_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Self-checking bench for mii_rx_framer: directed vector table, reset/enable
// sequences and randomized frames against a frame-level reference model.
module tb_mii_rx_framer;

    logic        mainclk = 1'b0;
    logic        rst, enable, eth_rx_clk, eth_rx_dv, eth_rxerr;
    logic [3:0]  eth_rxd;
    logic [7:0]  out_data;
    logic        out_valid, out_sof, out_eof, out_err;
    logic [10:0] frame_len;
    logic [15:0] frame_cnt, err_cnt;

    always #5 mainclk = ~mainclk;

    mii_rx_framer dut (
        .mainclk   (mainclk),
        .rst       (rst),
        .enable    (enable),
        .eth_rx_clk(eth_rx_clk),
        .eth_rx_dv (eth_rx_dv),
        .eth_rxd   (eth_rxd),
        .eth_rxerr (eth_rxerr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_err   (out_err),
        .frame_len (frame_len),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Captured strobes as {sof, eof, err, data}
    logic [10:0] cap[$];
    always @(negedge mainclk) begin
        if (out_valid) cap.push_back({out_sof, out_eof, out_err, out_data});
    end

    logic [7:0]  fb[$];
    logic [10:0] exp_q[$];
    int          m_fcnt = 0, m_ecnt = 0, m_flen = 0;

    function automatic logic [31:0] crc32_n(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_frame(input int len, input bit flip);
        logic [31:0] c;
        fb.delete();
        if (len >= 4) begin
            for (int i = 0; i < len - 4; i++) fb.push_back(8'($urandom));
            c = crc32_n(len - 4);
            fb.push_back(c[7:0]);
            fb.push_back(c[15:8]);
            fb.push_back(c[23:16]);
            fb.push_back(c[31:24]);
            if (flip) fb[len - 4][0] = ~fb[len - 4][0];
        end else begin
            for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
        end
    endtask

    task automatic drive_nib(input logic dv, input logic [3:0] d, input logic er);
        eth_rx_clk = 1'b1;
        eth_rx_dv  = dv;
        eth_rxd    = d;
        eth_rxerr  = er;
        #20;
        eth_rx_clk = 1'b0;
        #20;
    endtask

    task automatic send_frame(input int pre5, input logic [3:0] bad_nib, input int rxerr_at, input bit odd);
        logic [4:0] nq[$];
        for (int i = 0; i < pre5; i++) nq.push_back(5'h05);
        if (bad_nib != 4'h5) begin
            if (nq.size() > 0) nq.insert(1, {1'b0, bad_nib});
            else               nq.push_back({1'b0, bad_nib});
        end
        nq.push_back(5'h0D);
        for (int i = 0; i < fb.size(); i++) begin
            nq.push_back({1'(i == rxerr_at), fb[i][3:0]});
            nq.push_back({1'b0, fb[i][7:4]});
        end
        if (odd) nq.push_back(5'h0A);
        foreach (nq[i]) drive_nib(1'b1, nq[i][3:0], nq[i][4]);
        for (int i = 0; i < 8; i++) drive_nib(1'b0, 4'h0, 1'b0);
    endtask

    // Frame-level reference: what the receiver should emit and count for the frame in fb
    task automatic model_frame(input int pre5, input bit has_bad, input int rxerr_at,
                               input bit odd, input bit en);
        int n, k;
        bit fcs_ok, bad;
        exp_q.delete();
        n = fb.size();
        if (!en) return;
        if (pre5 < 1 || pre5 > 16 || has_bad) begin
            m_ecnt++;
            return;
        end
        fcs_ok = (n >= 4) && (crc32_n(n - 4) == {fb[n-1], fb[n-2], fb[n-3], fb[n-4]});
        bad = (rxerr_at >= 0 && rxerr_at < n) || odd || n < 64 || n > 1518 || !fcs_ok;
        k = (n > 1518) ? 1518 : n;
        for (int i = 0; i < k; i++)
            exp_q.push_back({1'(i == 0), 1'(i == n - 1), 1'(i == n - 1 && bad), fb[i]});
        if (n > 1518) exp_q.push_back({1'b0, 1'b1, bad, 8'd0});
        m_flen = (n > 2047) ? 2047 : n;
        if (bad) m_ecnt++;
        else     m_fcnt++;
    endtask

    task automatic compare_frame(input string tag);
        check({tag, ".strobe_count"}, 64'(cap.size()), 64'(exp_q.size()));
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            check($sformatf("%s.strobe[%0d]", tag, i), 64'(cap[i]), 64'(exp_q[i]));
        check({tag, ".frame_len"}, 64'(frame_len), 64'(m_flen));
        check({tag, ".frame_cnt"}, 64'(frame_cnt), 64'(m_fcnt));
        check({tag, ".err_cnt"},   64'(err_cnt),   64'(m_ecnt));
    endtask

    task automatic run_case(input string tag, input int len, input bit flip, input int pre5,
                            input logic [3:0] bad_nib, input int rxerr_at, input bit odd, input bit en);
        enable = en;
        make_frame(len, flip);
        model_frame(pre5, bad_nib != 4'h5, rxerr_at, odd, en);
        cap.delete();
        send_frame(pre5, bad_nib, rxerr_at, odd);
        repeat (4) @(negedge mainclk);
        compare_frame(tag);
    endtask

    typedef struct {
        int         len;
        bit         flip;
        int         pre5;
        logic [3:0] bad_nib;
        int         rxerr_at;
        bit         odd;
        bit         en;
        int         exp_strobes;
        bit         exp_err;
        int         exp_flen;
    } vec_t;

    vec_t tbl[15];
    logic [3:0] bad_set[4];

    initial begin
        tbl[0]  = '{64,   1'b0, 15, 4'h5, -1, 1'b0, 1'b1, 64,   1'b0, 64};
        tbl[1]  = '{64,   1'b1, 15, 4'h5, -1, 1'b0, 1'b1, 64,   1'b1, 64};
        tbl[2]  = '{40,   1'b0, 15, 4'h5, -1, 1'b0, 1'b1, 40,   1'b1, 40};
        tbl[3]  = '{63,   1'b0, 15, 4'h5, -1, 1'b0, 1'b1, 63,   1'b1, 63};
        tbl[4]  = '{1518, 1'b0, 15, 4'h5, -1, 1'b0, 1'b1, 1518, 1'b0, 1518};
        tbl[5]  = '{1519, 1'b0, 15, 4'h5, -1, 1'b0, 1'b1, 1519, 1'b1, 1519};
        tbl[6]  = '{1600, 1'b0, 15, 4'h5, -1, 1'b0, 1'b1, 1519, 1'b1, 1600};
        tbl[7]  = '{64,   1'b0, 15, 4'h7, -1, 1'b0, 1'b1, 0,    1'b0, 1600};
        tbl[8]  = '{64,   1'b0, 16, 4'h5, -1, 1'b0, 1'b1, 64,   1'b0, 64};
        tbl[9]  = '{64,   1'b0, 17, 4'h5, -1, 1'b0, 1'b1, 0,    1'b0, 64};
        tbl[10] = '{64,   1'b0, 1,  4'h5, -1, 1'b0, 1'b1, 64,   1'b0, 64};
        tbl[11] = '{64,   1'b0, 15, 4'h5, 20, 1'b0, 1'b1, 64,   1'b1, 64};
        tbl[12] = '{64,   1'b0, 15, 4'h5, -1, 1'b1, 1'b1, 64,   1'b1, 64};
        tbl[13] = '{64,   1'b0, 15, 4'h5, -1, 1'b0, 1'b0, 0,    1'b0, 64};
        tbl[14] = '{64,   1'b0, 15, 4'h5, -1, 1'b0, 1'b1, 64,   1'b0, 64};
        bad_set[0] = 4'h0; bad_set[1] = 4'h7; bad_set[2] = 4'hA; bad_set[3] = 4'hF;

        rst = 1'b1; enable = 1'b0;
        eth_rx_clk = 1'b0; eth_rx_dv = 1'b0; eth_rxd = 4'h0; eth_rxerr = 1'b0;
        repeat (5) @(negedge mainclk);
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.out_data",  64'(out_data),  64'(0));
        check("reset.frame_len", 64'(frame_len), 64'(0));
        check("reset.frame_cnt", 64'(frame_cnt), 64'(0));
        check("reset.err_cnt",   64'(err_cnt),   64'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive_nib(1'b0, 4'h0, 1'b0);

        // Directed vectors: table constants plus per-byte model comparison
        for (int v = 0; v < 15; v++) begin
            run_case($sformatf("vec%0d", v), tbl[v].len, tbl[v].flip, tbl[v].pre5,
                     tbl[v].bad_nib, tbl[v].rxerr_at, tbl[v].odd, tbl[v].en);
            check($sformatf("vec%0d.tbl_strobes", v), 64'(cap.size()), 64'(tbl[v].exp_strobes));
            check($sformatf("vec%0d.tbl_flen", v), 64'(frame_len), 64'(tbl[v].exp_flen));
            if (tbl[v].exp_strobes > 0) begin
                check($sformatf("vec%0d.tbl_eof", v),
                      64'((cap.size() > 0) ? cap[cap.size()-1][9] : 1'b0), 64'(1));
                check($sformatf("vec%0d.tbl_err", v),
                      64'((cap.size() > 0) ? cap[cap.size()-1][8] : 1'bx), 64'(tbl[v].exp_err));
            end
        end

        // Reset mid-frame, released while dv is still high
        enable = 1'b1;
        make_frame(100, 1'b0);
        cap.delete();
        fork
            send_frame(15, 4'h5, -1, 1'b0);
            begin
                repeat (400) @(negedge mainclk);
                rst = 1'b1;
                repeat (3) @(negedge mainclk);
                check("midrst.out_valid", 64'(out_valid), 64'(0));
                check("midrst.frame_cnt", 64'(frame_cnt), 64'(0));
                check("midrst.err_cnt",   64'(err_cnt),   64'(0));
                check("midrst.frame_len", 64'(frame_len), 64'(0));
                rst = 1'b0;
                cap.delete();
            end
        join
        repeat (4) @(negedge mainclk);
        check("midrst.dropped_strobes", 64'(cap.size()), 64'(0));
        m_fcnt = 0; m_ecnt = 0; m_flen = 0;
        check("midrst.frame_cnt_after", 64'(frame_cnt), 64'(0));
        run_case("post_rst", 80, 1'b0, 15, 4'h5, -1, 1'b0, 1'b1);

        // Randomized frames against the reference model
        for (int r = 0; r < 12; r++) begin
            int len, pre5, rxat;
            bit flip, odd, en;
            logic [3:0] bn;
            len  = ($urandom_range(0, 2) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 120);
            pre5 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 17) : 15;
            bn   = ($urandom_range(0, 7) == 0) ? bad_set[$urandom_range(0, 3)] : 4'h5;
            rxat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            flip = ($urandom_range(0, 3) == 0);
            odd  = ($urandom_range(0, 4) == 0);
            en   = ($urandom_range(0, 9) != 0);
            run_case($sformatf("rand%0d", r), len, flip, pre5, bn, rxat, odd, en);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
